// File: rtl/ram_arbiter.sv
// ram_arbiter: arbitrates one RAM port between instruction fetch and data access; define RAM_ARB_TIMEOUT_EN to enable the access timeout
module ram_arbiter #(
  parameter int WORD_W      = 32,
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [1:0]        ramstate,
  input  logic [WORD_W-1:0] ramload,
  output logic              ram_err
);
  typedef enum logic [1:0] {IDLE, ISERVE, DSERVE} state_t;
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;
  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_DSTREAK);
  state_t state_q, state_d;
  logic ren_q, ren_d, wen_q, wen_d;
  logic [WORD_W-1:0] addr_q, addr_d, store_q, store_d;
  logic [SW-1:0] streak_q, streak_d;
  logic serve, rsp, tmo_hit, done, dreq, dgrant;
  assign serve  = state_q != IDLE;
  assign rsp    = serve && (ramstate == RAM_ACCESS || ramstate == RAM_ERROR);
  assign done   = rsp || tmo_hit;
  assign dreq   = dREN || dWEN;
  assign dgrant = dreq && !(iREN && streak_q == SMAX);
  assign iwait  = iREN && !(state_q == ISERVE && done);
  assign dwait  = dreq && !(state_q == DSERVE && done);
  assign iload  = (state_q == ISERVE && rsp) ? ramload : '0;
  assign dload  = (state_q == DSERVE && rsp) ? ramload : '0;
  assign ram_err  = serve && (ramstate == RAM_ERROR || tmo_hit);
  assign ramREN   = ren_q;
  assign ramWEN   = wen_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;
`ifdef RAM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  assign tmo_hit = serve && !rsp && tmo_q == TW'(TIMEOUT);
  assign tmo_d   = (!serve || done) ? '0 : tmo_q + 1'b1;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) tmo_q <= '0;
    else tmo_q <= tmo_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = |TIMEOUT;
  assign tmo_hit    = 1'b0;
`endif
  always_comb begin
    state_d  = state_q;
    ren_d    = ren_q;
    wen_d    = wen_q;
    addr_d   = addr_q;
    store_d  = store_q;
    streak_d = streak_q;
    if (!serve) begin
      // a data grant with iREN set implies streak_q < SMAX, so the increment saturates by construction
      if (dgrant) begin
        state_d  = DSERVE;
        ren_d    = !dWEN;
        wen_d    = dWEN;
        addr_d   = daddr;
        store_d  = dstore;
        streak_d = iREN ? streak_q + 1'b1 : '0;
      end else if (iREN) begin
        state_d  = ISERVE;
        ren_d    = 1'b1;
        wen_d    = 1'b0;
        addr_d   = iaddr;
        streak_d = '0;
      end
    end else if (done) begin
      state_d = IDLE;
      ren_d   = 1'b0;
      wen_d   = 1'b0;
    end
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      store_q  <= '0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      ren_q    <= ren_d;
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      streak_q <= streak_d;
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_ram_arbiter;
  localparam int MAXD = 4;
  localparam int TMO  = 8;
  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, ram_err;
  logic [31:0] iload, dload, ramaddr, ramstore;
  int n_assert = 0;
  int n_fail   = 0;
  int owner, m_age, streak, k;
  bit m_wr;
  logic [31:0] m_addr, m_store;
  string seq;

  ram_arbiter #(.WORD_W(32), .MAX_DSTREAK(MAXD), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramstate(ramstate), .ramload(ramload), .ram_err(ram_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(string tag, logic obs, logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in();
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0;
    ramstate = 2'd0; ramload = 0;
  endtask

  task automatic reset_dut();
    nxt();
    RST = 1;
    idle_in();
    nxt();
    RST = 0;
  endtask

  // Transaction-level reference: who owns the RAM, what was latched, how many data grants in a row
  task automatic model_check();
    logic resp, fin;
    resp = ramstate == 2'd2 || ramstate == 2'd3;
    fin  = owner != 0 && resp;
    chk1("iwait", iwait, iREN && !(owner == 1 && fin));
    chk1("dwait", dwait, (dREN || dWEN) && !(owner == 2 && fin));
    chk("iload", iload, (owner == 1 && fin) ? ramload : 32'h0);
    chk("dload", dload, (owner == 2 && fin) ? ramload : 32'h0);
    chk1("ramREN", ramREN, owner != 0 && !m_wr);
    chk1("ramWEN", ramWEN, owner != 0 && m_wr);
    chk1("ram_err", ram_err, owner != 0 && ramstate == 2'd3);
    chk("ramaddr", ramaddr, m_addr);
    if (owner == 2) chk("ramstore", ramstore, m_store);
  endtask

  task automatic model_step();
    if (owner != 0) begin
      if (ramstate == 2'd2 || ramstate == 2'd3) owner = 0;
      else m_age++;
    end else if ((dREN || dWEN) && !(iREN && streak >= MAXD)) begin
      owner = 2; m_wr = dWEN; m_addr = daddr; m_store = dstore; m_age = 0;
      streak = iREN ? ((streak < MAXD) ? streak + 1 : MAXD) : 0;
    end else if (iREN) begin
      owner = 1; m_wr = 0; m_addr = iaddr; m_age = 0; streak = 0;
    end
  endtask

  initial begin
    RST = 1;
    idle_in();
    iREN = 1;
    nxt();
    #2;
    chk1("rst_ramREN", ramREN, 1'b0);
    chk1("rst_ramWEN", ramWEN, 1'b0);
    chk("rst_ramaddr", ramaddr, 32'h0);
    chk("rst_ramstore", ramstore, 32'h0);
    chk1("rst_ram_err", ram_err, 1'b0);
    chk1("rst_iwait", iwait, 1'b1);
    chk1("rst_dwait_idle", dwait, 1'b0);
    chk("rst_iload", iload, 32'h0);
    dREN = 1;
    #1;
    chk1("rst_dwait_req", dwait, 1'b1);
    chk("rst_dload", dload, 32'h0);
    nxt();
    #2;
    chk1("rst_hold_ramREN", ramREN, 1'b0);
    RST = 0;
    idle_in();

    // instruction only, ACCESS on the 4th serve cycle
    reset_dut();
    iREN = 1; iaddr = 32'h40;
    #2;
    chk1("i_idle_ramREN", ramREN, 1'b0);
    chk1("i_idle_iwait", iwait, 1'b1);
    nxt();
    ramstate = 2'd1;
    #2;
    chk1("i_ramREN", ramREN, 1'b1);
    chk("i_ramaddr", ramaddr, 32'h40);
    chk1("i_busy_iwait", iwait, 1'b1);
    chk1("i_dwait", dwait, 1'b0);
    repeat (2) begin
      nxt();
      #2;
      chk1("i_busy_iwait", iwait, 1'b1);
    end
    nxt();
    ramstate = 2'd2; ramload = 32'hDEADBEEF;
    #2;
    chk1("i_done_iwait", iwait, 1'b0);
    chk("i_done_iload", iload, 32'hDEADBEEF);
    chk1("i_done_dwait", dwait, 1'b0);
    chk1("i_done_err", ram_err, 1'b0);
    nxt();
    iREN = 0; ramstate = 2'd0;
    #2;
    chk1("i_after_ramREN", ramREN, 1'b0);
    chk("i_after_iload", iload, 32'h0);

    // simultaneous requests: data first, then instruction after a turnaround cycle
    reset_dut();
    iREN = 1; iaddr = 32'h0; dWEN = 1; daddr = 32'h100; dstore = 32'h12345678; ramstate = 2'd1;
    nxt();
    #2;
    chk1("sim_ramWEN", ramWEN, 1'b1);
    chk1("sim_ramREN", ramREN, 1'b0);
    chk("sim_ramaddr", ramaddr, 32'h100);
    chk("sim_ramstore", ramstore, 32'h12345678);
    chk1("sim_iwait", iwait, 1'b1);
    chk1("sim_dwait", dwait, 1'b1);
    nxt();
    ramstate = 2'd2;
    #2;
    chk1("sim_done_dwait", dwait, 1'b0);
    chk1("sim_done_iwait", iwait, 1'b1);
    nxt();
    dWEN = 0; ramstate = 2'd1;
    #2;
    chk1("sim_turn_ramWEN", ramWEN, 1'b0);
    chk1("sim_turn_ramREN", ramREN, 1'b0);
    nxt();
    #2;
    chk1("sim_i_ramREN", ramREN, 1'b1);
    chk("sim_i_ramaddr", ramaddr, 32'h0);

    // read with write: write wins
    reset_dut();
    dREN = 1; dWEN = 1; daddr = 32'h180; dstore = 32'h55AA55AA; ramstate = 2'd1;
    nxt();
    #2;
    chk1("rw_ramWEN", ramWEN, 1'b1);
    chk1("rw_ramREN", ramREN, 1'b0);

    // starvation guard
    reset_dut();
    iREN = 1; iaddr = 32'h40; dREN = 1; daddr = 32'h80; ramstate = 2'd2;
    seq = "";
    for (int c = 0; c < 40 && seq.len() < 7; c++) begin
      nxt();
      #2;
      if (ramREN || ramWEN) begin
        if (ramaddr == 32'h80) seq = {seq, "D"};
        else seq = {seq, "I"};
      end
    end
    n_assert++;
    assert (seq == "DDDDIDD") else begin
      n_fail++;
      $error("FAIL grant_order observed=%s expected=DDDDIDD", seq);
    end

    // ERROR response
    reset_dut();
    dREN = 1; daddr = 32'h200; ramstate = 2'd1;
    nxt();
    #2;
    chk1("err_ramREN", ramREN, 1'b1);
    chk("err_ramaddr", ramaddr, 32'h200);
    chk1("err_busy_flag", ram_err, 1'b0);
    nxt();
    ramstate = 2'd3; ramload = 32'hCAFEF00D;
    #2;
    chk1("err_dwait", dwait, 1'b0);
    chk1("err_flag", ram_err, 1'b1);
    chk("err_dload", dload, 32'hCAFEF00D);
    nxt();
    dREN = 0; ramstate = 2'd0;
    #2;
    chk1("err_after_flag", ram_err, 1'b0);
    chk1("err_after_ramREN", ramREN, 1'b0);

    // reset mid-transaction
    reset_dut();
    dREN = 1; daddr = 32'h300; ramstate = 2'd1;
    nxt();
    #2;
    chk1("mrst_ramREN_before", ramREN, 1'b1);
    iREN = 1; iaddr = 32'h44; dREN = 0; RST = 1;
    #1;
    chk1("mrst_ramREN", ramREN, 1'b0);
    chk1("mrst_ramWEN", ramWEN, 1'b0);
    chk1("mrst_ram_err", ram_err, 1'b0);
    nxt();
    RST = 0;
    #2;
    chk1("mrst_idle_ramREN", ramREN, 1'b0);
    nxt();
    #2;
    chk1("mrst_i_ramREN", ramREN, 1'b1);
    chk("mrst_i_ramaddr", ramaddr, 32'h44);

    // RAM stuck at BUSY
    reset_dut();
    iREN = 1; iaddr = 32'h60; ramstate = 2'd1; ramload = 32'hFFFFFFFF;
    nxt();
    #2;
    for (k = 0; k < 120 && iwait === 1'b1; k++) begin
      nxt();
      #2;
    end
`ifdef RAM_ARB_TIMEOUT_EN
    chk("tmo_cycles", k, TMO);
    chk("tmo_iload", iload, 32'h0);
    chk1("tmo_err", ram_err, 1'b1);
`else
    chk("stuck_cycles", k, 120);
    chk1("stuck_ramREN", ramREN, 1'b1);
`endif

    // randomized traffic against the model; responses forced before any timeout can fire
    reset_dut();
    owner = 0; m_wr = 0; m_addr = 0; m_store = 0; streak = 0; m_age = 0;
    for (int c = 0; c < 600; c++) begin
      nxt();
      iREN = $urandom_range(0, 3) != 0;
      dREN = $urandom_range(0, 2) == 0;
      dWEN = $urandom_range(0, 2) == 0;
      iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
      ramstate = 2'($urandom_range(0, 3));
      if (owner != 0 && m_age >= 5) ramstate = 2'd2;
      #2;
      model_check();
      model_step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
